ntt_butterfly_unit: RTL and testbench
=====================================

NTT_BUTTERFLY_UNIT -- requirements
Module: ntt_butterfly_unit

Interface
REQ-001 Parameter W, default 30, SHALL set the coefficient and twiddle width.
REQ-002 Parameter Q, default 998244353, SHALL set the prime modulus; legal only if Q odd and Q < 2^W (elaboration error otherwise).
REQ-003 Parameter TAG_W, default 8, SHALL set the width of the passthrough tag (address/index sideband).
REQ-004 clk  input  1  SHALL be the single clock; all state on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL mark a valid input transaction.
REQ-007 in_ready  output  1  SHALL mark that the unit accepts an input this cycle.
REQ-008 mode  input  1  SHALL select the butterfly: 0 = Cooley-Tukey (CT, forward), 1 = Gentleman-Sande (GS, inverse).
REQ-009 a, b  input  W each  SHALL be the operands, each < Q.
REQ-010 w  input  W  SHALL be the twiddle factor, < Q.
REQ-011 tag_in  input  TAG_W  SHALL be sideband data carried with the transaction.
REQ-012 out_valid  output  1  SHALL mark valid results.
REQ-013 out_ready  input  1  SHALL mark that the consumer accepts results this cycle.
REQ-014 A, B  output  W each  SHALL be the butterfly results, each in [0, Q-1].
REQ-015 tag_out  output  TAG_W  SHALL be tag_in of the transaction shown on A/B.

Function
REQ-016 CT: A SHALL be (a + w*b) mod Q; B SHALL be (a - w*b) mod Q.
REQ-017 GS: A SHALL be (a + b) mod Q; B SHALL be ((a - b) mod Q) * w mod Q.
REQ-018 Transfer SHALL occur on an edge where valid and ready are both 1 (input and output sides independently).
REQ-019 Latency SHALL be exactly 5 cycles for both modes: a transaction accepted at edge k SHALL show out_valid=1 after edge k+5, absent stalls.
REQ-020 Throughput SHALL be one transaction per cycle; mode MAY change every transaction, with no bubble and no reordering.
REQ-021 Stall: when out_valid=1 and out_ready=0 the whole pipeline SHALL hold; in_ready SHALL be out_ready OR NOT out_valid (combinational path permitted).
REQ-022 While stalled, A, B, tag_out SHALL remain stable.
REQ-023 Bubbles SHALL propagate as invalid slots; no bubble collapse required.
REQ-024 Modular multiply SHALL use Barrett reduction with mu = floor(2^(2W)/Q) computed at elaboration, final correction yielding a fully reduced result.
REQ-025 Add/sub SHALL use one conditional correction (subtract Q if sum >= Q; add Q if difference < 0).
REQ-026 Inputs >= Q SHALL leave handshake and timing unaffected; result values are then unspecified.
REQ-027 out_valid and data outputs SHALL be driven directly from registers.

Reset
REQ-028 On rst_n=0 all stage valid bits, out_valid, A, B and tag_out SHALL clear to 0 immediately, asynchronously.
REQ-029 Transactions in flight at reset SHALL be discarded; none SHALL emerge after release.
REQ-030 in_ready SHALL be 1 during and after reset (out_valid=0).

Structure
REQ-031 Shared package ntt_pkg SHALL hold mode encodings (MODE_CT, MODE_GS), default W and Q, and the Barrett mu constant function.
REQ-032 Sub-module mod_mult (pipelined W-bit Barrett multiplier, enable input, fixed 3-cycle latency) SHALL be instantiated once.
REQ-033 Datapath delay lines SHALL align operands and tag so both modes meet REQ-019.

Verification
REQ-034 CT, a=5 b=3 w=2, out_ready=1 -> 5 cycles later A=11, B=998244352.
REQ-035 GS, a=5 b=3 w=2 -> A=8, B=4; same 5-cycle latency.
REQ-036 Wrap: CT, a=998244352 b=1 w=1 -> A=0, B=998244351; CT, a=0 b=998244352 w=998244352 -> A=1, B=998244352.
REQ-037 Back-to-back alternating CT/GS for 20 cycles with tag_in = 0..19 -> outputs in order, tags 0..19, values match a reference model, one per cycle.
REQ-038 Hold out_ready=0 for 7 cycles with full pipeline -> in_ready=0, A/B/tag_out stable, no loss or duplication on release.
REQ-039 Assert rst_n=0 with 3 transactions in flight -> out_valid=0 and outputs 0 at once; none emerge after release.

Source files
------------

// File: rtl/ntt_pkg.sv
// ntt_pkg
//   Shared definitions for the NTT butterfly datapath.
//   - mode_e       : butterfly selection (Cooley-Tukey forward / Gentleman-Sande inverse)
//   - DEFAULT_W/Q  : default coefficient width and prime modulus
//   - MULT_LATENCY : pipeline depth of mod_mult, used to size the bypass delay lines
//   - barrett_mu() : floor(2^(2w)/q), evaluated at elaboration time
package ntt_pkg;

    localparam int unsigned     DEFAULT_W    = 30;
    localparam longint unsigned DEFAULT_Q    = 64'd998244353;
    localparam int unsigned     MULT_LATENCY = 3;

    typedef enum logic {
        MODE_CT = 1'b0,
        MODE_GS = 1'b1
    } mode_e;

    // Wide enough for any w up to 63, so 2^(2w) never overflows.
    function automatic logic [127:0] barrett_mu(input int unsigned w, input longint unsigned q);
        logic [127:0] num;
        num = 128'd1 << (2 * w);
        return num / {64'd0, q};
    endfunction

endpackage

// File: rtl/mod_mult.sv
// mod_mult
//   Pipelined modular multiplier p = (x * y) mod Q using Barrett reduction.
//   Fixed latency of MULT_LATENCY (3) enabled cycles; every register advances
//   only when en is high, so the whole pipe freezes on a downstream stall.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     en         : advance the pipeline this cycle
//     x, y       : operands, expected < Q
//     p          : fully reduced product, registered
module mod_mult
    import ntt_pkg::*;
#(
    parameter int unsigned     W = DEFAULT_W,
    parameter longint unsigned Q = DEFAULT_Q
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] p
);

    localparam int unsigned   PW  = 2 * W;
    localparam int unsigned   MW  = 2 * W + 1;
    localparam int unsigned   EW  = PW + MW;
    // The Barrett remainder before correction is below 3Q, so W+2 bits hold it exactly.
    localparam int unsigned   RW  = W + 2;
    localparam logic [MW-1:0] MU  = MW'(barrett_mu(W, Q));
    localparam logic [RW-1:0] Q_R = RW'(Q);

    logic [PW-1:0] prod1;
    logic [RW-1:0] prod2_lo;
    logic [W-1:0]  quot2;
    logic [W-1:0]  quot_est;
    logic [RW-1:0] rem_raw;
    logic [RW-1:0] rem_c1;
    logic [W-1:0]  rem_final;

    // Quotient estimate floor(prod * mu / 2^(2W)); it undershoots the true
    // quotient by at most 2, which the two corrections below absorb.
    assign quot_est = W'((EW'(prod1) * EW'(MU)) >> PW);

    // Only the low W+2 bits of prod - quot*Q are needed, since the true
    // difference is known to be below 2^(W+2).
    always_comb begin
        rem_raw   = prod2_lo - RW'(RW'(quot2) * Q_R);
        rem_c1    = (rem_raw >= Q_R) ? (rem_raw - Q_R) : rem_raw;
        rem_final = (rem_c1 >= Q_R) ? W'(rem_c1 - Q_R) : W'(rem_c1);
    end

    // Stage 1: raw product. Stage 2: quotient estimate. Stage 3: reduced result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod1    <= '0;
            prod2_lo <= '0;
            quot2    <= '0;
            p        <= '0;
        end else if (en) begin
            prod1    <= PW'(x) * PW'(y);
            prod2_lo <= prod1[RW-1:0];
            quot2    <= quot_est;
            p        <= rem_final;
        end
    end

endmodule

// File: rtl/ntt_butterfly_unit.sv
// ntt_butterfly_unit
//   Pipelined NTT butterfly with valid/ready handshake, 5-cycle latency for
//   both butterfly flavours and one transaction per cycle.
//     CT (mode=0): A = a + w*b,  B = a - w*b            (mod Q)
//     GS (mode=1): A = a + b,    B = (a - b) * w         (mod Q)
//   Pipeline: s1 input register -> s2 pre-add/sub and multiplier operand
//   select -> 3-stage mod_mult (sideband in matching delay line) -> output
//   register with post-add/sub. A single advance signal freezes everything
//   while the output holds an unaccepted result.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     in_valid, in_ready  : input handshake (in_ready = out_ready | ~out_valid)
//     mode, a, b, w       : butterfly select, operands and twiddle
//     tag_in, tag_out     : sideband carried alongside the transaction
//     out_valid, out_ready: output handshake
//     A, B                : registered butterfly results in [0, Q-1]
module ntt_butterfly_unit
    import ntt_pkg::*;
#(
    parameter int unsigned     W     = DEFAULT_W,
    parameter longint unsigned Q     = DEFAULT_Q,
    parameter int unsigned     TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     w,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     A,
    output logic [W-1:0]     B,
    output logic [TAG_W-1:0] tag_out
);

    localparam int unsigned DL = MULT_LATENCY;
    localparam logic [W:0]  Q_A = (W + 1)'(Q);

    generate
        if ((W < 2) || (W > 63) || ((Q % 64'd2) == 64'd0) || (Q >= (64'd1 << W))) begin : g_bad_params
            $error("ntt_butterfly_unit: Q must be odd and below 2**W (2 <= W <= 63)");
        end
    endgenerate

    // Single-correction modular add/sub; operands are assumed already < Q.
    function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        return (s >= Q_A) ? W'(s - Q_A) : W'(s);
    endfunction

    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] d;
        d = {1'b0, x} - {1'b0, y};
        return d[W] ? W'(d + Q_A) : W'(d);
    endfunction

    logic             advance;

    logic             s1_valid;
    mode_e            s1_mode;
    logic [W-1:0]     s1_a;
    logic [W-1:0]     s1_b;
    logic [W-1:0]     s1_w;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    mode_e            s2_mode;
    logic [W-1:0]     s2_keep;
    logic [W-1:0]     s2_mx;
    logic [W-1:0]     s2_my;
    logic [TAG_W-1:0] s2_tag;

    logic             dl_valid [DL];
    mode_e            dl_mode  [DL];
    logic [W-1:0]     dl_keep  [DL];
    logic [TAG_W-1:0] dl_tag   [DL];

    logic [W-1:0]     prod;

    // The pipeline moves only when the output slot is empty or being drained,
    // which is exactly the condition for accepting a new input.
    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    // Stage 1: register the incoming transaction (bubbles enter as valid=0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_CT;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_w     <= '0;
            s1_tag   <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_mode  <= mode_e'(mode);
            s1_a     <= a;
            s1_b     <= b;
            s1_w     <= w;
            s1_tag   <= tag_in;
        end
    end

    // Stage 2: GS does its add/sub before the multiply, CT after it. The
    // "keep" field is the value that bypasses the multiplier: a+b for GS
    // (final A) and a for CT (input to the post-add/sub).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_mode  <= MODE_CT;
            s2_keep  <= '0;
            s2_mx    <= '0;
            s2_my    <= '0;
            s2_tag   <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_mode  <= s1_mode;
            s2_keep  <= (s1_mode == MODE_GS) ? add_mod(s1_a, s1_b) : s1_a;
            s2_mx    <= (s1_mode == MODE_GS) ? sub_mod(s1_a, s1_b) : s1_b;
            s2_my    <= s1_w;
            s2_tag   <= s1_tag;
        end
    end

    mod_mult #(
        .W (W),
        .Q (Q)
    ) u_mod_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (advance),
        .x     (s2_mx),
        .y     (s2_my),
        .p     (prod)
    );

    // Sideband delay line, as deep as the multiplier, so dl_*[DL-1] lines up
    // with prod.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DL; i++) begin
                dl_valid[i] <= 1'b0;
                dl_mode[i]  <= MODE_CT;
                dl_keep[i]  <= '0;
                dl_tag[i]   <= '0;
            end
        end else if (advance) begin
            dl_valid[0] <= s2_valid;
            dl_mode[0]  <= s2_mode;
            dl_keep[0]  <= s2_keep;
            dl_tag[0]   <= s2_tag;
            for (int i = 1; i < DL; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_mode[i]  <= dl_mode[i-1];
                dl_keep[i]  <= dl_keep[i-1];
                dl_tag[i]   <= dl_tag[i-1];
            end
        end
    end

    // Output stage: CT finishes with a +/- w*b, GS already has its results.
    // Outputs come straight from these registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            A         <= '0;
            B         <= '0;
            tag_out   <= '0;
        end else if (advance) begin
            out_valid <= dl_valid[DL-1];
            tag_out   <= dl_tag[DL-1];
            if (dl_mode[DL-1] == MODE_GS) begin
                A <= dl_keep[DL-1];
                B <= prod;
            end else begin
                A <= add_mod(dl_keep[DL-1], prod);
                B <= sub_mod(dl_keep[DL-1], prod);
            end
        end
    end

endmodule

// File: tb/tb_ntt_butterfly_unit.sv
// tb_ntt_butterfly_unit
//   Self-checking bench for ntt_butterfly_unit. A negedge monitor keeps a
//   queue of expected results computed with plain modular arithmetic and
//   compares every output transfer in order; directed sequences cover the
//   known vectors, latency, back-to-back mode switching, stall hold and
//   mid-flight reset, followed by randomized traffic with backpressure.
module tb_ntt_butterfly_unit;

    localparam int              W     = 30;
    localparam int              TAG_W = 8;
    localparam longint unsigned Q     = 64'd998244353;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     w;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic [TAG_W-1:0] tag_out;

    typedef struct {
        longint unsigned expA;
        longint unsigned expB;
        longint unsigned tag;
    } expect_t;

    expect_t          expQueue[$];
    int               checkCount = 0;
    int               errorCount = 0;

    ntt_butterfly_unit #(
        .W     (W),
        .Q     (Q),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .w         (w),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A         (A),
        .B         (B),
        .tag_out   (tag_out)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something never terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", name, observed, expected);
        end
    endtask

    // Reference butterfly straight from the definitions, using 64-bit arithmetic.
    function automatic void refButterfly(input bit m, input longint unsigned x, input longint unsigned y,
                                         input longint unsigned tw, output longint unsigned ra,
                                         output longint unsigned rb);
        longint unsigned t;
        if (!m) begin
            t  = (tw * y) % Q;
            ra = (x + t) % Q;
            rb = (x + Q - t) % Q;
        end else begin
            ra = (x + y) % Q;
            rb = (((x + Q - y) % Q) * tw) % Q;
        end
    endfunction

    function automatic longint unsigned randOperand();
        int unsigned r;
        r = $urandom_range(0, 7);
        if (r == 0) return 64'd0;
        if (r == 1) return Q - 1;
        return longint'($urandom) % Q;
    endfunction

    // Advance to just after the next rising edge; all inputs change here.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit m, input longint unsigned x, input longint unsigned y,
                                 input longint unsigned tw, input longint unsigned tg);
        in_valid = 1'b1;
        mode     = m;
        a        = W'(x);
        b        = W'(y);
        w        = W'(tw);
        tag_in   = TAG_W'(tg);
    endtask

    // Monitor: sampled at the falling edge, so the values seen here are the
    // ones the next rising edge acts on.
    initial begin
        bit               prevStall;
        logic [W-1:0]     holdA;
        logic [W-1:0]     holdB;
        logic [TAG_W-1:0] holdTag;
        longint unsigned  ea;
        longint unsigned  eb;
        expect_t          e;
        prevStall = 1'b0;
        holdA     = '0;
        holdB     = '0;
        holdTag   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall) begin
                    checkOutput("hold_A", A, holdA);
                    checkOutput("hold_B", B, holdB);
                    checkOutput("hold_tag", tag_out, holdTag);
                    checkOutput("hold_valid", out_valid, 1);
                end
                checkOutput("in_ready_rule", in_ready, out_ready || !out_valid);
                if (in_valid && in_ready) begin
                    refButterfly(mode, a, b, w, ea, eb);
                    e.expA = ea;
                    e.expB = eb;
                    e.tag  = tag_in;
                    expQueue.push_back(e);
                end
                if (out_valid && out_ready) begin
                    if (expQueue.size() == 0) begin
                        checkOutput("spurious_out", 1, 0);
                    end else begin
                        e = expQueue.pop_front();
                        checkOutput("out_A", A, e.expA);
                        checkOutput("out_B", B, e.expB);
                        checkOutput("out_tag", tag_out, e.tag);
                    end
                end
                prevStall = out_valid && !out_ready;
                holdA     = A;
                holdB     = B;
                holdTag   = tag_out;
            end
        end
    end

    // One transaction into an empty pipe: checks latency and fixed results.
    task automatic runSingle(input bit m, input longint unsigned x, input longint unsigned y,
                             input longint unsigned tw, input longint unsigned expA,
                             input longint unsigned expB, input string name);
        int cycles;
        applyStimulus(m, x, y, tw, 8'h5A);
        stepCycle();
        in_valid = 1'b0;
        cycles   = 0;
        while (!out_valid && cycles < 20) begin
            stepCycle();
            cycles++;
        end
        checkOutput({name, "_latency"}, cycles, 5);
        checkOutput({name, "_A"}, A, expA);
        checkOutput({name, "_B"}, B, expB);
        stepCycle();
    endtask

    // 20 back-to-back transactions alternating CT/GS, tags 0..19.
    task automatic runBurst();
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    applyStimulus(i % 2, randOperand(), randOperand(), randOperand(), i);
                    checkOutput("burst_in_ready", in_ready, 1);
                    stepCycle();
                end
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk);
                    #2;
                    checkOutput("burst_out_valid", out_valid, 1);
                    checkOutput("burst_tag_order", tag_out, i);
                end
            end
        join
        stepCycle();
    endtask

    // Fill the pipe with out_ready low, hold for 7 cycles, then drain.
    task automatic runStall();
        int guard;
        out_ready = 1'b0;
        guard     = 0;
        while (!out_valid && guard < 30) begin
            applyStimulus($urandom_range(0, 1), randOperand(), randOperand(), randOperand(), 100 + guard);
            stepCycle();
            guard++;
        end
        checkOutput("stall_fill", out_valid, 1);
        for (int i = 0; i < 7; i++) begin
            checkOutput("stall_in_ready", in_ready, 0);
            stepCycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) stepCycle();
        checkOutput("stall_drain", expQueue.size(), 0);
    endtask

    // Reset with three transactions in flight; none may come out afterwards.
    task automatic runReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(i % 2, randOperand(), randOperand(), randOperand(), 200 + i);
            stepCycle();
        end
        in_valid = 1'b0;
        stepCycle();
        #2;
        rst_n = 1'b0;
        expQueue.delete();
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_A", A, 0);
        checkOutput("rst_B", B, 0);
        checkOutput("rst_tag", tag_out, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        stepCycle();
        for (int i = 0; i < 8; i++) begin
            checkOutput("post_reset_quiet", out_valid, 0);
            stepCycle();
        end
    endtask

    // Random traffic with random bubbles and backpressure.
    task automatic runRandom(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus($urandom_range(0, 1), randOperand(), randOperand(), randOperand(),
                          $urandom_range(0, 255));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            stepCycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        mode      = 1'b0;
        a         = '0;
        b         = '0;
        w         = '0;
        tag_in    = '0;
        out_ready = 1'b1;
        #3;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_A", A, 0);
        checkOutput("reset_B", B, 0);
        checkOutput("reset_tag", tag_out, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        #19;
        rst_n = 1'b1;
        stepCycle();

        $display("[TB] directed vectors");
        runSingle(1'b0, 5, 3, 2, 11, 998244352, "ct_basic");
        runSingle(1'b1, 5, 3, 2, 8, 4, "gs_basic");
        runSingle(1'b0, Q - 1, 1, 1, 0, Q - 2, "ct_wrap_hi");
        runSingle(1'b0, 0, Q - 1, Q - 1, 1, Q - 1, "ct_wrap_lo");

        $display("[TB] back-to-back burst");
        runBurst();

        $display("[TB] stall hold");
        runStall();

        $display("[TB] reset in flight");
        runReset();

        $display("[TB] random traffic");
        runRandom(400);
        repeat (15) stepCycle();
        checkOutput("final_drain", expQueue.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
